// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: load-use and mult/div hazard stall, branch flush and mult/div occupancy tracking
module pipeline_stall_controller #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemReadFromIDEX,
  input  logic [31:0] ID_Instruction,
  input  logic [31:0] EX_Instruction,
  input  logic        ID_IsMulDiv,
  input  logic        ID_ReadsHiLo,
  input  logic        BranchTaken,
  output logic        PC_WriteEnable,
  output logic        IFID_WriteEnable,
  output logic        IDEX_Bubble,
  output logic        IFID_Flush,
  output logic        MulDivStart,
  output logic        MulDivBusy,
  output logic [15:0] StallCount
);
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        load_use, md_hazard, stall, start;
  logic        unused_bits;
  assign id_rs = ID_Instruction[25:21];
  assign id_rt = ID_Instruction[20:16];
  assign ex_rt = EX_Instruction[20:16];
  assign unused_bits = ^{ID_Instruction[31:26], ID_Instruction[15:0], EX_Instruction[31:21], EX_Instruction[15:0]};
  // Hazard detection and pipeline control; reset forces a frozen front end with a bubble into EX
  always_comb begin
    load_use         = MemReadFromIDEX && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
    md_hazard        = state_q == MD_BUSY && (ID_IsMulDiv || ID_ReadsHiLo);
    stall            = load_use || md_hazard;
    start            = Reset && state_q == RUN && ID_IsMulDiv && !load_use;
    PC_WriteEnable   = Reset && !stall;
    IFID_WriteEnable = Reset && !stall;
    IDEX_Bubble      = !Reset || stall;
    IFID_Flush       = Reset && BranchTaken && !stall;
    MulDivStart      = start;
    MulDivBusy       = state_q == MD_BUSY;
    StallCount       = stall_cnt_q;
  end
  // Mult/div occupancy: Start arms the counter, busy ends on the edge where it has reached zero
  always_comb begin
    state_d     = start ? MD_BUSY : (state_q == MD_BUSY && cnt_q == 6'd0) ? RUN : state_q;
    cnt_d       = start ? 6'(MULDIV_CYCLES - 1) : (state_q == MD_BUSY && cnt_q != 6'd0) ? cnt_q - 6'd1 : cnt_q;
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  // State registers; reset abandons any in-flight mult/div immediately
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      cnt_q       <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vectors with a queue scoreboard and a negedge monitor
module tb_pipeline_stall_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic [31:0] ex_instr = 32'd0;
  logic        is_md = 1'b0;
  logic        reads_hl = 1'b0;
  logic        br_taken = 1'b0;
  logic        pc_we, ifid_we, bubble, flush, md_start, md_busy;
  logic [15:0] stall_count;
  typedef struct {
    string       name;
    logic [21:0] exp;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  pipeline_stall_controller #(.MULDIV_CYCLES(4)) dut (
    .Clock(clk), .Reset(rst_n), .MemReadFromIDEX(mem_read),
    .ID_Instruction(id_instr), .EX_Instruction(ex_instr),
    .ID_IsMulDiv(is_md), .ID_ReadsHiLo(reads_hl), .BranchTaken(br_taken),
    .PC_WriteEnable(pc_we), .IFID_WriteEnable(ifid_we), .IDEX_Bubble(bubble),
    .IFID_Flush(flush), .MulDivStart(md_start), .MulDivBusy(md_busy),
    .StallCount(stall_count)
  );
  always #5 clk = ~clk;
  function automatic logic [21:0] e(input logic pc, ifid, bub, fl, st, bz, input logic [15:0] sc);
    return {pc, ifid, bub, fl, st, bz, sc};
  endfunction
  task automatic step(input string nm, input logic rst, mr, input logic [4:0] ex_rt, id_rs, id_rt,
                      input logic md, hl, br, input logic [21:0] exp);
    @(posedge clk);
    #1;
    rst_n    = rst;
    mem_read = mr;
    ex_instr = {6'b100011, 5'd31, ex_rt, 16'h0004};
    id_instr = {6'b000000, id_rs, id_rt, 16'h2020};
    is_md    = md;
    reads_hl = hl;
    br_taken = br;
    q.push_back('{nm, exp});
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [21:0] act;
      x = q.pop_front();
      act = {pc_we, ifid_we, bubble, flush, md_start, md_busy, stall_count};
      compared++;
      if (act !== x.exp) begin
        mismatched++;
        $display("FAIL %s: got pc=%b ifid=%b bub=%b flush=%b start=%b busy=%b cnt=%h, expected pc=%b ifid=%b bub=%b flush=%b start=%b busy=%b cnt=%h",
                 x.name, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                 x.exp[21], x.exp[20], x.exp[19], x.exp[18], x.exp[17], x.exp[16], x.exp[15:0]);
      end
    end
  end
  initial begin
    step("reset_hold",   0, 1, 5, 5, 0, 1, 1, 1, e(0,0,1,0,0,0,16'd0));
    step("idle",         1, 0, 0, 0, 0, 0, 0, 0, e(1,1,0,0,0,0,16'd0));
    step("loaduse_rs",   1, 1, 5, 5, 9, 0, 0, 0, e(0,0,1,0,0,0,16'd0));
    step("load_rt_zero", 1, 1, 0, 0, 0, 0, 0, 0, e(1,1,0,0,0,0,16'd1));
    step("no_memread",   1, 0, 5, 5, 5, 0, 0, 0, e(1,1,0,0,0,0,16'd1));
    step("lu_rt_branch", 1, 1, 7, 3, 7, 1, 0, 1, e(0,0,1,0,0,0,16'd1));
    step("branch_flush", 1, 0, 7, 3, 7, 0, 0, 1, e(1,1,0,1,0,0,16'd2));
    step("md_start",     1, 0, 0, 1, 2, 1, 0, 0, e(1,1,0,0,1,0,16'd2));
    step("hilo_busy1",   1, 0, 0, 1, 2, 0, 1, 0, e(0,0,1,0,0,1,16'd2));
    step("hilo_busy2",   1, 0, 0, 1, 2, 0, 1, 0, e(0,0,1,0,0,1,16'd3));
    step("hilo_busy3",   1, 0, 0, 1, 2, 0, 1, 0, e(0,0,1,0,0,1,16'd4));
    step("hilo_busy4",   1, 0, 0, 1, 2, 0, 1, 0, e(0,0,1,0,0,1,16'd5));
    step("hilo_run",     1, 0, 0, 1, 2, 0, 1, 0, e(1,1,0,0,0,0,16'd6));
    step("md_start2",    1, 0, 0, 1, 2, 1, 0, 0, e(1,1,0,0,1,0,16'd6));
    step("indep_busy",   1, 0, 0, 4, 6, 0, 0, 0, e(1,1,0,0,0,1,16'd6));
    step("md_in_busy2",  1, 0, 0, 1, 2, 1, 0, 0, e(0,0,1,0,0,1,16'd6));
    step("md_in_busy3",  1, 0, 0, 1, 2, 1, 0, 0, e(0,0,1,0,0,1,16'd7));
    step("md_in_busy4",  1, 0, 0, 1, 2, 1, 0, 0, e(0,0,1,0,0,1,16'd8));
    step("md_restart",   1, 0, 0, 1, 2, 1, 0, 0, e(1,1,0,0,1,0,16'd9));
    step("branch_busy1", 1, 0, 0, 4, 6, 0, 0, 1, e(1,1,0,1,0,1,16'd9));
    step("reset_mid_md", 0, 1, 5, 5, 0, 1, 1, 1, e(0,0,1,0,0,0,16'd0));
    step("post_rst_md",  1, 0, 0, 1, 2, 1, 0, 0, e(1,1,0,0,1,0,16'd0));
    step("post_busy1",   1, 0, 0, 4, 6, 0, 0, 0, e(1,1,0,0,0,1,16'd0));
    for (int i = 0; i < 65540; i++)
      step("sat_stall", 1, 1, 9, 9, 1, 0, 0, 0,
           e(0,0,1,0,0,(i < 3) ? 1'b1 : 1'b0, (i > 65535) ? 16'hFFFF : 16'(i)));
    step("sat_hold",     1, 0, 0, 0, 0, 0, 0, 0, e(1,1,0,0,0,0,16'hFFFF));
    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MULDIV_CYCLES, default 32, SHALL set the multiply/divide unit latency in cycles; legal range 2..63.
REQ-002 Clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  SHALL be asynchronous, active-low reset.
REQ-004 MemReadFromIDEX  in  1  SHALL mean the instruction in EX is a load.
REQ-005 ID_Instruction  in  32  SHALL be the instruction in ID; rs=[25:21], rt=[20:16].
REQ-006 EX_Instruction  in  32  SHALL be the instruction in EX; load destination=[20:16].
REQ-007 ID_IsMulDiv  in  1  SHALL mean the ID instruction is mult/multu/div/divu.
REQ-008 ID_ReadsHiLo  in  1  SHALL mean the ID instruction is mfhi/mflo.
REQ-009 BranchTaken  in  1  SHALL mean a branch/jump resolved taken in ID this cycle.
REQ-010 PC_WriteEnable  out  1  SHALL mean the PC updates this cycle.
REQ-011 IFID_WriteEnable  out  1  SHALL mean the IF/ID register updates this cycle.
REQ-012 IDEX_Bubble  out  1  SHALL mean ID/EX control fields are zeroed (nop) this cycle.
REQ-013 IFID_Flush  out  1  SHALL mean the IF/ID register loads a nop this cycle.
REQ-014 MulDivStart  out  1  SHALL be a one-cycle launch pulse to the mult/div unit.
REQ-015 MulDivBusy  out  1  SHALL mean the mult/div unit holds an unfinished operation.
REQ-016 StallCount  out  16  SHALL count stall cycles since reset.

Function
REQ-017 LoadUse SHALL be MemReadFromIDEX and EX[20:16]!=0 and (EX[20:16]==ID[25:21] or EX[20:16]==ID[20:16]), combinational.
REQ-018 States SHALL be RUN and MD_BUSY, with a 6-bit down-counter Cnt.
REQ-019 MdHazard SHALL be (state==MD_BUSY) and (ID_IsMulDiv or ID_ReadsHiLo).
REQ-020 Stall SHALL be LoadUse or MdHazard; when Stall: PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_Bubble=1, IFID_Flush=0, MulDivStart=0.
REQ-021 When not Stall: PC_WriteEnable=1, IFID_WriteEnable=1, IDEX_Bubble=0.
REQ-022 IFID_Flush SHALL equal BranchTaken and not Stall; BranchTaken during a stall is ignored (re-evaluated next cycle).
REQ-023 In RUN, MulDivStart SHALL equal ID_IsMulDiv and not LoadUse; same edge: state->MD_BUSY, Cnt<=MULDIV_CYCLES-1.
REQ-024 In MD_BUSY: MulDivBusy=1; each edge Cnt decrements; at the edge where Cnt==0, state->RUN; Busy thus lasts exactly MULDIV_CYCLES cycles after the Start cycle.
REQ-025 A mult/div or mfhi/mflo arriving in MD_BUSY SHALL stall through the final busy cycle and proceed in the first RUN cycle (new Start issued there for mult/div).
REQ-026 MulDivBusy SHALL be 0 in RUN; MulDivStart SHALL never assert in MD_BUSY.
REQ-027 StallCount SHALL increment on every edge where Stall==1 and saturate at 16'hFFFF.
REQ-028 Independent instructions in ID SHALL flow without stall while MD_BUSY.

Reset
REQ-029 While Reset==0: state=RUN, Cnt=0, StallCount=0, PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_Bubble=1, IFID_Flush=0, MulDivStart=0, MulDivBusy=0, regardless of other inputs.
REQ-030 Reset assertion mid-MD_BUSY SHALL abandon the operation immediately; first cycle after release is RUN with normal REQ-020/021 outputs.

Verification
REQ-031 MemReadFromIDEX=1, EX[20:16]=5, ID rs=5 -> PC_WE=0, IFID_WE=0, IDEX_Bubble=1, StallCount +1; same with EX[20:16]=0 -> no stall.
REQ-032 MULDIV_CYCLES=4, ID_IsMulDiv=1 at cycle 0 -> MulDivStart=1 at cycle 0 only, MulDivBusy=1 cycles 1-4, 0 at cycle 5.
REQ-033 Same, ID_ReadsHiLo=1 held from cycle 1 -> stall cycles 1-4, PC_WE=1 at cycle 5, StallCount=4.
REQ-034 LoadUse and BranchTaken both 1 -> IFID_Flush=0, stall; next cycle LoadUse=0, BranchTaken=1 -> IFID_Flush=1, PC_WE=1.
REQ-035 Reset pulled low at Busy cycle 2 -> MulDivBusy=0 asynchronously, StallCount=0; after release ID_IsMulDiv=1 -> immediate new MulDivStart.
REQ-036 Force 65540 stall cycles -> StallCount holds 16'hFFFF.
